// File: rtl/snax_tcdm_rr_arbiter.sv
// snax_tcdm_rr_arbiter
//   Round-robin arbiter that funnels NumReq HWPE request streams onto one
//   shared TCDM port. Requests pass through combinationally. A presented but
//   stalled request is locked until it is accepted. Each accepted request
//   records its requester index in a route FIFO so that the in-order TCDM
//   responses can be steered back to the requester that issued them.
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   req_q_*_i / _o       per-requester request channel (valid/ready/addr/write/data)
//   req_p_valid_o        one-hot response strobe to the owning requester
//   req_p_data_o         response data, broadcast to all requesters
//   tcdm_q_*             shared TCDM request channel (strb tied all-ones)
//   tcdm_p_*             TCDM response channel, in request order
//   busy_o               a request is locked or responses are outstanding
//   err_o                sticky: a response arrived with nothing outstanding
//
// state | meaning
// IDLE  | no request locked; arbitrate among valid requesters
// LOCK  | winner presented but not yet accepted; hold it, no re-arbitration
module snax_tcdm_rr_arbiter #(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0]                    req_q_valid_i,
  output logic [NumReq-1:0]                    req_q_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_q_addr_i,
  input  logic [NumReq-1:0]                    req_q_write_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     req_q_data_i,
  output logic [NumReq-1:0]                    req_p_valid_o,
  output logic [DataWidth-1:0]                 req_p_data_o,
  output logic                                 tcdm_q_valid_o,
  input  logic                                 tcdm_q_ready_i,
  output logic [AddrWidth-1:0]                 tcdm_q_addr_o,
  output logic                                 tcdm_q_write_o,
  output logic [DataWidth-1:0]                 tcdm_q_data_o,
  output logic [DataWidth/8-1:0]               tcdm_q_strb_o,
  input  logic                                 tcdm_p_valid_i,
  input  logic [DataWidth-1:0]                 tcdm_p_data_i,
  output logic                                 busy_o,
  output logic                                 err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e          state_q;
  logic [IdxW-1:0] ptr_q, lock_idx_q;
  logic [IdxW-1:0] rr_idx, win_idx, next_ptr, cand;
  logic            rr_found;

  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            full, empty, accept, push, pop;
  logic            err_q;

  // First valid requester at or after ptr_q, wrapping.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NumReq);
      if (!rr_found && req_q_valid_i[cand]) begin
        rr_idx   = cand;
        rr_found = 1'b1;
      end
    end
  end

  // Full/empty come from the registered count: a pop in the same cycle does
  // not free a slot for a grant until the next cycle.
  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);

  assign win_idx  = (state_q == LOCK) ? lock_idx_q : rr_idx;
  assign next_ptr = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;

  // Gated by rst_ni so the request channel is silent while reset is held,
  // even if requesters keep their valids up.
  assign tcdm_q_valid_o = rst_ni & ((state_q == LOCK) | (rr_found & ~full));
  assign accept         = tcdm_q_valid_o & tcdm_q_ready_i;
  assign req_q_ready_o  = accept ? (NumReq'(1) << win_idx) : '0;

  assign tcdm_q_addr_o  = req_q_addr_i[win_idx];
  assign tcdm_q_write_o = req_q_write_i[win_idx];
  assign tcdm_q_data_o  = req_q_data_i[win_idx];
  assign tcdm_q_strb_o  = '1;

  assign push = accept;
  assign pop  = tcdm_p_valid_i & ~empty;

  assign req_p_valid_o = pop ? (NumReq'(1) << fifo_q[rd_ptr_q]) : '0;
  assign req_p_data_o  = tcdm_p_data_i;

  assign busy_o = (state_q == LOCK) | ~empty;
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ptr_q <= next_ptr;
          end else if (tcdm_q_valid_o) begin
            state_q    <= LOCK;
            lock_idx_q <= win_idx;
          end
        end
        LOCK: begin
          if (accept) begin
            state_q <= IDLE;
            ptr_q   <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (tcdm_p_valid_i && empty) err_q <= 1'b1;
    end
  end

  // Route storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= win_idx;
  end

endmodule

// File: tb/tb_snax_tcdm_rr_arbiter.sv
module tb_snax_tcdm_rr_arbiter;

  localparam int NR = 3;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int MO = 8;

  logic                  clk_i, rst_ni;
  logic [NR-1:0]         req_valid, req_q_ready_o, req_write, req_p_valid_o;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_data;
  logic [DW-1:0]         req_p_data_o, tcdm_q_data_o, p_data;
  logic                  tcdm_q_valid_o, tcdm_ready, tcdm_q_write_o, p_valid;
  logic [AW-1:0]         tcdm_q_addr_o;
  logic [DW/8-1:0]       tcdm_q_strb_o;
  logic                  busy_o, err_o;

  int total = 0;
  int bad   = 0;

  snax_tcdm_rr_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_q_valid_i  (req_valid),
    .req_q_ready_o  (req_q_ready_o),
    .req_q_addr_i   (req_addr),
    .req_q_write_i  (req_write),
    .req_q_data_i   (req_data),
    .req_p_valid_o  (req_p_valid_o),
    .req_p_data_o   (req_p_data_o),
    .tcdm_q_valid_o (tcdm_q_valid_o),
    .tcdm_q_ready_i (tcdm_ready),
    .tcdm_q_addr_o  (tcdm_q_addr_o),
    .tcdm_q_write_o (tcdm_q_write_o),
    .tcdm_q_data_o  (tcdm_q_data_o),
    .tcdm_q_strb_o  (tcdm_q_strb_o),
    .tcdm_p_valid_i (p_valid),
    .tcdm_p_data_i  (p_data),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of requester indices awaiting their response,
  // the round-robin start position and the requester currently held.
  int mq[$];
  int mptr  = 0;
  int mpend = -1;
  bit merr  = 1'b0;

  always @(negedge clk_i) begin : model
    int off;
    bit ev;
    logic [NR-1:0] er, ep;
    if (!rst_ni) begin
      mq.delete();
      mptr  = 0;
      mpend = -1;
      merr  = 1'b0;
    end else begin
      off = -1;
      if (mpend >= 0) off = mpend;
      else if (mq.size() < MO) begin
        for (int k = 0; k < NR; k++)
          if (off < 0 && req_valid[(mptr + k) % NR]) off = (mptr + k) % NR;
      end
      ev = (off >= 0);
      er = '0;
      if (ev && tcdm_ready) er[off] = 1'b1;
      ep = '0;
      if (p_valid && mq.size() > 0) ep[mq[0]] = 1'b1;

      chk("m_q_valid", 64'(tcdm_q_valid_o), 64'(ev));
      if (ev) begin
        chk("m_addr",  64'(tcdm_q_addr_o),  64'(req_addr[off]));
        chk("m_write", 64'(tcdm_q_write_o), 64'(req_write[off]));
        chk("m_data",  tcdm_q_data_o,       req_data[off]);
      end
      chk("m_q_ready", 64'(req_q_ready_o), 64'(er));
      chk("m_p_valid", 64'(req_p_valid_o), 64'(ep));
      if (p_valid) chk("m_p_data", req_p_data_o, p_data);
      chk("m_busy", 64'(busy_o), 64'((mpend >= 0) || (mq.size() > 0)));
      chk("m_err",  64'(err_o),  64'(merr));

      if (p_valid) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else merr = 1'b1;
      end
      if (ev) begin
        if (tcdm_ready) begin
          mq.push_back(off);
          mptr  = (off + 1) % NR;
          mpend = -1;
        end else begin
          mpend = off;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic new_fields(input int i);
    req_addr[i]  = AW'({$urandom(), $urandom()});
    req_data[i]  = {$urandom(), $urandom()};
    req_write[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    tcdm_ready = 1'b0;
    p_valid    = 1'b0;
    p_data     = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int n, outst;
    int pv_rate, rdy_rate, req_rate;
    logic [NR-1:0] acc;

    rst_ni = 1'b0;
    clear_inputs();
    for (int i = 0; i < NR; i++) new_fields(i);
    step();
    step();
    chk("rst_q_valid", 64'(tcdm_q_valid_o), 64'(0));
    chk("rst_busy",    64'(busy_o),         64'(0));
    chk("rst_err",     64'(err_o),          64'(0));
    chk("rst_ready",   64'(req_q_ready_o),  64'(0));
    rst_ni = 1'b1;

    // All requesters valid, TCDM always ready: strict rotation then routing.
    do_reset();
    for (int i = 0; i < NR; i++) new_fields(i);
    req_valid  = '1;
    tcdm_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 64'(req_q_ready_o), 64'(1 << (k % 3)));
      if (k == 0) chk("strb", 64'(tcdm_q_strb_o), 64'(8'hff));
      step();
    end
    req_valid  = '0;
    tcdm_ready = 1'b0;
    p_valid    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p_data = DW'(k + 64'h100);
      #1;
      chk("rr_route", 64'(req_p_valid_o), 64'(1 << (k % 3)));
      chk("rr_pdata", req_p_data_o, 64'(k + 64'h100));
      step();
    end
    p_valid = 1'b0;
    #1;
    chk("rr_idle_busy", 64'(busy_o), 64'(0));

    // Stall on requester 1; requester 0 appears mid-lock and must wait.
    do_reset();
    for (int i = 0; i < NR; i++) new_fields(i);
    req_valid = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) req_valid[0] = 1'b1;
      if (c == 5) tcdm_ready = 1'b1;
      #1;
      chk("lock_addr",  64'(tcdm_q_addr_o), 64'(req_addr[1]));
      chk("lock_ready", 64'(req_q_ready_o), (c == 5) ? 64'(2) : 64'(0));
      step();
    end
    req_valid[1] = 1'b0;
    #1;
    chk("lock_next", 64'(req_q_ready_o), 64'(1));
    step();
    req_valid  = '0;
    tcdm_ready = 1'b0;
    p_valid    = 1'b1;
    #1;
    chk("lock_route1", 64'(req_p_valid_o), 64'(2));
    step();
    #1;
    chk("lock_route0", 64'(req_p_valid_o), 64'(1));
    step();
    p_valid = 1'b0;

    // Fill the route FIFO with no responses.
    do_reset();
    for (int i = 0; i < NR; i++) new_fields(i);
    req_valid  = 3'b001;
    tcdm_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_q_ready_o[0]) n++;
      if (c >= 8) chk("full_block", 64'(tcdm_q_valid_o), 64'(0));
      step();
    end
    chk("full_count", 64'(n), 64'(8));
    p_valid = 1'b1;
    #1;
    chk("full_pop_block", 64'(tcdm_q_valid_o), 64'(0));
    chk("full_pop_route", 64'(req_p_valid_o),  64'(1));
    step();
    p_valid = 1'b0;
    #1;
    chk("ninth_accept", 64'(req_q_ready_o), 64'(1));
    step();

    // Occupancy 7, simultaneous push and pop keeps it at 7.
    req_valid = '0;
    p_valid   = 1'b1;
    step();
    req_valid = 3'b100;
    #1;
    chk("simul_route", 64'(req_p_valid_o), 64'(1));
    chk("simul_acc",   64'(req_q_ready_o), 64'(4));
    step();
    p_valid = 1'b0;
    #1;
    chk("simul_fill", 64'(req_q_ready_o), 64'(4));
    step();
    #1;
    chk("simul_full", 64'(tcdm_q_valid_o), 64'(0));
    req_valid = '0;
    p_valid   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("drain_route", 64'(req_p_valid_o), (k < 6) ? 64'(1) : 64'(4));
      step();
    end
    p_valid = 1'b0;

    // Response with nothing outstanding.
    do_reset();
    p_valid = 1'b1;
    p_data  = 64'hdead_beef;
    #1;
    chk("orphan_pvalid", 64'(req_p_valid_o), 64'(0));
    step();
    p_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("orphan_err", 64'(err_o), 64'(1));
      step();
    end
    do_reset();
    #1;
    chk("orphan_err_clr", 64'(err_o), 64'(0));

    // Reset with three outstanding and a locked request.
    do_reset();
    for (int i = 0; i < NR; i++) new_fields(i);
    req_valid  = '1;
    tcdm_ready = 1'b1;
    step();
    step();
    step();
    req_valid  = 3'b010;
    tcdm_ready = 1'b0;
    #1;
    chk("pre_rst_lock", 64'(tcdm_q_valid_o), 64'(1));
    step();
    req_valid = 3'b111;
    p_valid   = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_q_valid", 64'(tcdm_q_valid_o), 64'(0));
    chk("arst_ready",   64'(req_q_ready_o),  64'(0));
    chk("arst_p_valid", 64'(req_p_valid_o),  64'(0));
    chk("arst_busy",    64'(busy_o),         64'(0));
    chk("arst_err",     64'(err_o),          64'(0));
    step();
    step();
    p_valid   = 1'b0;
    req_valid = '0;
    rst_ni    = 1'b1;
    p_valid   = 1'b1;
    #1;
    chk("post_rst_pvalid", 64'(req_p_valid_o), 64'(0));
    step();
    p_valid    = 1'b0;
    req_valid  = 3'b111;
    tcdm_ready = 1'b1;
    #1;
    chk("post_rst_grant", 64'(req_q_ready_o), 64'(1));
    chk("post_rst_err",   64'(err_o),         64'(1));
    step();

    // Randomized traffic with legal protocol: valids held until accepted,
    // responses only for accepted requests.
    do_reset();
    outst    = 0;
    acc      = '0;
    pv_rate  = 50;
    rdy_rate = 50;
    req_rate = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        pv_rate  = $urandom_range(0, 100);
        rdy_rate = $urandom_range(10, 100);
        req_rate = $urandom_range(10, 100);
      end
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 99) < req_rate)) begin
          req_valid[i] = 1'b1;
          new_fields(i);
        end
      end
      tcdm_ready = ($urandom_range(0, 99) < rdy_rate);
      p_valid    = (outst > 0) && ($urandom_range(0, 99) < pv_rate);
      p_data     = {$urandom(), $urandom()};
      #1;
      acc = req_q_ready_o;
      if (tcdm_q_valid_o && tcdm_ready) outst++;
      if (p_valid) outst--;
      step();
      req_valid = req_valid & ~acc;
    end
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
